sprite_fetch_arbiter: RTL and testbench
=======================================

// Module: sprite_fetch_arbiter
// PURPOSE
//  Shares the single combinational sprite texture ROM read port (6-bit col/row
//  in, CHANNEL_BITS*3 texel out) between NUM_REQ texel requesters, e.g. the
//  sprite column renderer and a background prefetcher.
//  Round-robin arbitration, with a strict-priority override for requester 0.
//  Registered address and data stages give a fixed 2-cycle accept-to-response
//  latency and a throughput of one texel per clock.
// PARAMETERS
//  CHANNEL_BITS  2  bits per colour channel; texel width is CHANNEL_BITS*3
//  NUM_REQ       2  number of requesters (2..4)
// PORTS
//  clk        in   1               system clock; all state on rising edge
//  reset_n    in   1               asynchronous active-low reset
//  en         in   1               1 = grants allowed; 0 = no new grants, pipeline drains
//  urgent     in   1               1 = requester 0 has strict priority
//  req_valid  in   NUM_REQ         per-requester fetch request
//  req_col    in   NUM_REQ*6       packed texel column; slot i = [6i+5:6i]
//  req_row    in   NUM_REQ*6       packed texel row; slot i = [6i+5:6i]
//  req_ready  out  NUM_REQ         one-hot grant; request accepted when valid&ready
//  rom_col    out  6               registered ROM column address
//  rom_row    out  6               registered ROM row address
//  rom_val    in   CHANNEL_BITS*3  ROM texel, valid in the same cycle as rom_col/rom_row
//  rsp_valid  out  NUM_REQ         one-hot, 1-cycle pulse: texel for that requester
//  rsp_data   out  CHANNEL_BITS*3  registered texel, valid while any rsp_valid bit is high
// BEHAVIOUR
//  Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rom_col=0,
//   rom_row=0, stage-1 valid/id cleared, rr_ptr=NUM_REQ-1 (requester 0 wins first).
//  Grant (combinational, same cycle): req_ready=0 when en=0 or req_valid=0.
//   - urgent=1 and req_valid[0]=1 -> grant requester 0.
//   - otherwise the first valid requester scanning rr_ptr+1, rr_ptr+2, ...
//     modulo NUM_REQ is granted.
//   - At most one req_ready bit is high. req_ready never depends on rsp state
//     (no response backpressure).
//  Cycle T (accept): rom_col/rom_row <= granted col/row; s1_valid<=1;
//   s1_id<=granted index; rr_ptr<=granted index, including urgent grants.
//   No grant: s1_valid<=0; rom_col/rom_row and rr_ptr hold.
//  Cycle T+1: ROM is addressed. rsp_data<=rom_val and rsp_valid<=one-hot(s1_id)
//   if s1_valid, else rsp_valid<=0 and rsp_data holds.
//  Cycle T+2: rsp_valid pulse visible. Latency = 2 clocks; back-to-back accepts
//   give back-to-back responses in accept order.
//  en falling: grants stop that cycle. Requests already accepted still complete
//   (up to 2 pulses). en rising: arbitration resumes from the held rr_ptr.
//  Requester dropping valid without a grant is legal; nothing is recorded.
//  Address wrap: col/row are 6-bit; 63 is the last texel, no carry or clamp.
//  Async reset mid-transfer discards in-flight responses; no pulse after release.
//  Index arithmetic: rr_ptr is clog2(NUM_REQ) bits, with explicit modulo NUM_REQ
//   (not binary wrap) when NUM_REQ is not a power of 2.
// TESTING
//  1 Reset: hold reset_n=0 with all req_valid=1 -> all outputs 0, req_ready=0;
//    first cycle after release grants requester 0.
//  2 Single fetch: req0 col=5 row=9, ROM model data[{col,row}] -> rom_col=5,
//    rom_row=9 at T+1; rsp_valid=2'b01 with rsp_data=data[{6'd5,6'd9}] at T+2
//    only.
//  3 Fairness: both valid continuously for 8 cycles, urgent=0 -> grants
//    alternate 0,1,0,1...; rsp_valid alternates 01,10 starting at cycle 2.
//  4 Urgent: both valid, urgent=1 for 4 cycles -> req_ready=2'b01 every cycle;
//    drop urgent -> next grant goes to requester 1.
//  5 en/drain: 3 back-to-back accepts, then en=0 -> exactly 3 rsp pulses, no
//    further grants; en=1 resumes at rr_ptr+1.
//  6 Mid-flight reset: accept at T, assert reset_n=0 at T+1 -> no rsp_valid
//    pulse; rsp_data=0.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: shares one combinational texture ROM read port
// between NUM_REQ requesters. Round-robin grant with a strict-priority
// override for requester 0, then a registered address stage and a registered
// data stage, so every accepted request gets its texel exactly 2 clocks later.
module sprite_fetch_arbiter #(
   parameter int CHANNEL_BITS = 2,
   parameter int NUM_REQ      = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      en,
   input  logic                      urgent,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*6-1:0]      req_col,
   input  logic [NUM_REQ*6-1:0]      req_row,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [5:0]                rom_col,
   output logic [5:0]                rom_row,
   input  logic [CHANNEL_BITS*3-1:0] rom_val,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [CHANNEL_BITS*3-1:0] rsp_data
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = CHANNEL_BITS * 3;

   logic [NUM_REQ-1:0][5:0] col_a;
   logic [NUM_REQ-1:0][5:0] row_a;
   logic [PW-1:0]           rr_ptr;
   logic [PW-1:0]           scan_idx;
   logic [PW-1:0]           gnt_idx;
   logic                    gnt_any;
   logic                    s1_valid;
   logic [PW-1:0]           s1_id;

   // unpack the flat per-requester address buses into lane arrays
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign col_a[i] = req_col[6*i +: 6];
      assign row_a[i] = req_row[6*i +: 6];
   end

   // grant select: urgent override for requester 0, else first valid after rr_ptr;
   // nothing is granted while reset is held so no request is acknowledged and lost
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      if (en && reset_n) begin
         if (urgent && req_valid[0]) begin
            gnt_any = 1'b1;
         end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               // explicit modulo keeps the scan correct for non power-of-2 NUM_REQ
               scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
               if (!gnt_any && req_valid[scan_idx]) begin
                  gnt_any = 1'b1;
                  gnt_idx = scan_idx;
               end
            end
         end
      end
   end

   assign req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;

   // address stage, round-robin pointer, and data stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_col   <= '0;
         rom_row   <= '0;
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         rr_ptr    <= PW'(NUM_REQ - 1);
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         s1_valid <= gnt_any;
         if (gnt_any) begin
            rom_col <= col_a[gnt_idx];
            rom_row <= row_a[gnt_idx];
            s1_id   <= gnt_idx;
            rr_ptr  <= gnt_idx;
         end
         if (s1_valid) begin
            rsp_valid <= NUM_REQ'(1) << s1_id;
            rsp_data  <= TW'(rom_val);
         end else begin
            rsp_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed bench for sprite_fetch_arbiter: a queue-based reference model checks
// every cycle, and literal expectations at key points pin the model itself.
module tb_sprite_fetch_arbiter;

   localparam int CB = 2;
   localparam int N  = 2;
   localparam int TW = CB * 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          en;
   logic          urgent;
   logic [N-1:0]  req_valid;
   logic [N*6-1:0] req_col;
   logic [N*6-1:0] req_row;
   logic [N-1:0]  req_ready;
   logic [5:0]    rom_col;
   logic [5:0]    rom_row;
   logic [TW-1:0] rom_val;
   logic [N-1:0]  rsp_valid;
   logic [TW-1:0] rsp_data;

   int errors = 0;
   int checks = 0;

   sprite_fetch_arbiter #(.CHANNEL_BITS(CB), .NUM_REQ(N)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .urgent(urgent),
      .req_valid(req_valid), .req_col(req_col), .req_row(req_row),
      .req_ready(req_ready), .rom_col(rom_col), .rom_row(rom_row),
      .rom_val(rom_val), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   // texture ROM contents: data[{col,row}]
   function automatic logic [TW-1:0] rom_f(input logic [5:0] c, input logic [5:0] r);
      logic [5:0] a;
      logic [5:0] b;
      a = c * 6'd5;
      b = r + 6'd17;
      return TW'(a ^ b);
   endfunction

   assign rom_val = rom_f(rom_col, rom_row);

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      int            id;
      logic [TW-1:0] data;
      int            due;
   } rsp_t;

   rsp_t          m_q[$];
   int            m_last = N - 1;
   int            cyc = 0;
   logic [5:0]    exp_col = '0;
   logic [5:0]    exp_row = '0;
   logic [TW-1:0] exp_rd = '0;

   always @(negedge clk) begin
      int g;
      int exp_rv;
      logic [5:0] c;
      logic [5:0] r;
      cyc++;
      if (!reset_n) begin
         m_q.delete();
         m_last  = N - 1;
         exp_col = '0;
         exp_row = '0;
         exp_rd  = '0;
         chk("m_rst_ready", int'(req_ready), 0);
         chk("m_rst_rspv", int'(rsp_valid), 0);
         chk("m_rst_rspd", int'(rsp_data), 0);
         chk("m_rst_col", int'(rom_col), 0);
         chk("m_rst_row", int'(rom_row), 0);
      end else begin
         exp_rv = 0;
         if (m_q.size() > 0 && m_q[0].due == cyc) begin
            exp_rv = 1 << m_q[0].id;
            exp_rd = m_q[0].data;
            void'(m_q.pop_front());
         end
         chk("m_rspv", int'(rsp_valid), exp_rv);
         chk("m_rspd", int'(rsp_data), int'(exp_rd));
         chk("m_col", int'(rom_col), int'(exp_col));
         chk("m_row", int'(rom_row), int'(exp_row));
         g = -1;
         if (en) begin
            if (urgent && req_valid[0]) g = 0;
            else
               for (int k = 1; k <= N; k++)
                  if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
         end
         chk("m_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
         if (g >= 0) begin
            c = req_col[g*6 +: 6];
            r = req_row[g*6 +: 6];
            exp_col = c;
            exp_row = r;
            m_q.push_back('{id: g, data: rom_f(c, r), due: cyc + 2});
            m_last = g;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i);
      req_col = {6'(63 - i), 6'(i * 9)};
      req_row = {6'(i * 7 + 1), 6'(63 - 2 * i)};
   endtask

   initial begin
      int pulses;
      reset_n = 1'b0; en = 1'b1; urgent = 1'b0;
      req_valid = 2'b11; req_col = '0; req_row = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_rspv", int'(rsp_valid), 0);
      chk("rst_col", int'(rom_col), 0);

      // release with both requesting: requester 0 first, then alternate
      tick(); reset_n = 1'b1; set_addr(0);
      @(negedge clk); chk("rel_grant0", int'(req_ready), 1);
      for (int i = 1; i < 8; i++) begin
         tick(); set_addr(i);
         @(negedge clk);
         if (i == 1) chk("fair_g1", int'(req_ready), 2);
         if (i == 2) chk("fair_rsp01", int'(rsp_valid), 1);
         if (i == 3) chk("fair_rsp10", int'(rsp_valid), 2);
      end
      tick(); req_valid = '0;
      repeat (3) tick();

      // single fetch, col 5 row 9
      req_valid = 2'b01; req_col = {6'd0, 6'd5}; req_row = {6'd0, 6'd9};
      @(negedge clk); chk("single_rdy", int'(req_ready), 1);
      tick(); req_valid = '0;
      @(negedge clk);
      chk("single_col", int'(rom_col), 5);
      chk("single_row", int'(rom_row), 9);
      chk("single_rspv_t1", int'(rsp_valid), 0);
      tick();
      @(negedge clk);
      chk("single_rspv_t2", int'(rsp_valid), 1);
      chk("single_data", int'(rsp_data), 3);
      tick();
      @(negedge clk); chk("single_rspv_t3", int'(rsp_valid), 0);

      // urgent override, then requester 1 next
      tick(); req_valid = 2'b11; urgent = 1'b1; set_addr(20);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); chk("urgent_rdy", int'(req_ready), 1);
         tick();
      end
      urgent = 1'b0;
      @(negedge clk); chk("urgent_drop", int'(req_ready), 2);
      tick(); req_valid = '0;
      repeat (3) tick();

      // three accepts, then en=0 drains exactly three responses
      req_valid = 2'b11; set_addr(40); pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (|rsp_valid) pulses++;
         if (k >= 3) chk("drain_rdy", int'(req_ready), 0);
         tick();
         if (k == 2) en = 1'b0;
      end
      chk("drain_pulses", pulses, 3);
      en = 1'b1;
      @(negedge clk); chk("resume_rdy", int'(req_ready), 2);
      tick(); req_valid = '0;
      repeat (3) tick();

      // wrap-address accept, then reset while it is in flight
      req_valid = 2'b01; req_col = {6'd0, 6'd63}; req_row = {6'd0, 6'd63};
      @(negedge clk); chk("mid_rdy", int'(req_ready), 1);
      tick(); reset_n = 1'b0; req_valid = '0;
      @(negedge clk); chk("mid_rspv0", int'(rsp_valid), 0);
      tick();
      @(negedge clk);
      chk("mid_rspv1", int'(rsp_valid), 0);
      chk("mid_rspd", int'(rsp_data), 0);
      tick(); reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk("post_rst_rspv", int'(rsp_valid), 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
